memory_cycle_ft: RTL and testbench

- MEM stage directly downstream of the execute stage. It consumes the EX/MEM pipeline outputs, performs the data-memory access and drives the MEM/WB pipeline registers.
- Data memory words carry an even-parity bit, and load-time parity errors are detected.
- A faulty word address is remapped to one of a small set of spare word registers. This gives word-level spare replacement, in the same way the execute stage swaps to a spare ALU.
- Sticky fault status is reported to the top level.

---
 rtl/memory_cycle_ft.sv | 165 ++++++++++++++++
 tb/tb_memory_cycle_ft.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle_ft.sv
// memory_cycle_ft: MEM pipeline stage with parity-protected data memory,
// word-level spare replacement of faulty addresses and sticky fault status.
// Optional build macro MEMORY_FAULT_INJECT_EN adds inject_parity_err, which
// stores the inverted parity bit into array words.
module memory_cycle_ft #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned NUM_SPARES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
`ifdef MEMORY_FAULT_INJECT_EN
  input  logic        inject_parity_err,
`endif
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        mem_fault_flag,
  output logic        spares_exhausted,
  output logic [31:0] fault_addr
);

  localparam int unsigned IW = $clog2(DEPTH);
  // Pointer must be able to reach NUM_SPARES to mean "all spares used".
  localparam int unsigned PW = $clog2(NUM_SPARES + 1);

  logic [31:0]           mem_data [DEPTH];
  logic                  mem_par  [DEPTH];
  logic [DEPTH-1:0]      written;
  logic [NUM_SPARES-1:0] remap_valid;
  logic [IW-1:0]         remap_tag  [NUM_SPARES];
  logic [31:0]           spare_data [NUM_SPARES];
  logic [PW-1:0]         alloc_ptr;

  logic [IW-1:0]         index;
  logic [NUM_SPARES-1:0] hit;
  logic                  any_hit;
  logic                  is_store;
  logic                  is_load;
  logic                  arr_written;
  logic [31:0]           arr_word;
  logic [31:0]           spare_word;
  logic [31:0]           read_data;
  logic                  store_par;
  logic                  parity_err;
  logic                  alloc_free;

  assign index       = ALU_ResultM[IW+1:2];
  assign is_store    = MemWriteM;
  assign is_load     = ResultSrcM && !MemWriteM;
  assign arr_written = written[index];
  assign arr_word    = mem_data[index];
  assign any_hit     = |hit;
  assign alloc_free  = alloc_ptr < PW'(NUM_SPARES);

`ifdef MEMORY_FAULT_INJECT_EN
  assign store_par = (^WriteDataM) ^ inject_parity_err;
`else
  assign store_par = ^WriteDataM;
`endif

  // Remap lookup: entries never alias, so at most one hit bit is set.
  always_comb begin
    hit        = '0;
    spare_word = '0;
    for (int k = 0; k < NUM_SPARES; k++) begin
      if (remap_valid[k] && (remap_tag[k] == index)) begin
        hit[k]     = 1'b1;
        spare_word = spare_data[k];
      end
    end
  end

  // Unwritten array words read as zero and never flag a parity error.
  assign read_data  = any_hit ? spare_word : (arr_written ? arr_word : 32'h0);
  assign parity_err = is_load && !any_hit && arr_written && (mem_par[index] != ^arr_word);

  // Array storage is not reset; a store dropped by reset stays invisible
  // because its written bit is cleared.
  always_ff @(posedge clk) begin
    if (is_store && !any_hit) begin
      mem_data[index] <= WriteDataM;
      mem_par[index]  <= store_par;
    end
  end

  // Per-word written bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written <= '0;
    end else if (is_store && !any_hit) begin
      written[index] <= 1'b1;
    end
  end

  // Spare words: store updates on hit, raw data captured on allocation.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SPARES; k++) begin
      if (is_store && hit[k]) begin
        spare_data[k] <= WriteDataM;
      end else if (parity_err && alloc_free && (alloc_ptr == PW'(k))) begin
        spare_data[k] <= arr_word;
      end
    end
  end

  // Remap table allocation and sticky fault status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remap_valid      <= '0;
      for (int k = 0; k < NUM_SPARES; k++) begin
        remap_tag[k] <= '0;
      end
      alloc_ptr        <= '0;
      mem_fault_flag   <= 1'b0;
      spares_exhausted <= 1'b0;
      fault_addr       <= '0;
    end else if (parity_err) begin
      mem_fault_flag <= 1'b1;
      if (!mem_fault_flag) begin
        fault_addr <= ALU_ResultM;
      end
      if (alloc_free) begin
        for (int k = 0; k < NUM_SPARES; k++) begin
          if (alloc_ptr == PW'(k)) begin
            remap_valid[k] <= 1'b1;
            remap_tag[k]   <= index;
          end
        end
        alloc_ptr <= alloc_ptr + PW'(1);
      end else begin
        spares_exhausted <= 1'b1;
      end
    end
  end

  // MEM/WB pipeline registers; the read port is sampled every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= read_data;
    end
  end

endmodule

// File: tb/tb_memory_cycle_ft.sv
// Testbench for memory_cycle_ft: directed scenarios plus randomized traffic,
// checked every cycle against a word-level behavioural model.
module tb_memory_cycle_ft;

  localparam int DEPTH = 1024;
  localparam int NSP   = 2;
  localparam int IW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        ResultSrcM = 1'b0;
  logic [4:0]  RD_M = '0;
  logic [31:0] PCPlus4M = '0;
  logic [31:0] ALU_ResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        inject_parity_err = 1'b0;
  logic        RegWriteW, ResultSrcW, mem_fault_flag, spares_exhausted;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, fault_addr;

  int checks = 0;
  int errors = 0;

  memory_cycle_ft #(.DEPTH(DEPTH), .NUM_SPARES(NSP)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM),
`ifdef MEMORY_FAULT_INJECT_EN
    .inject_parity_err(inject_parity_err),
`endif
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .mem_fault_flag(mem_fault_flag), .spares_exhausted(spares_exhausted),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain word array, written/bad flags, remap list.
  logic [31:0] mdata [DEPTH];
  bit          mwr   [DEPTH];
  bit          mbad  [DEPTH];
  int          rtag  [$];
  logic [31:0] rsp   [$];

  logic        e_rw, e_rs, e_flag, e_exh;
  logic [4:0]  e_rd;
  logic [31:0] e_pc, e_alu, e_rdata, e_faddr;
  bit          e_rchk;

  always @(posedge clk or negedge rst) begin : mdl
    int idx;
    int k;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mwr[i] = 1'b0;
      rtag.delete();
      rsp.delete();
      e_rw = 0; e_rs = 0; e_rd = 0; e_pc = 0; e_alu = 0; e_rdata = 0;
      e_flag = 0; e_exh = 0; e_faddr = 0; e_rchk = 1;
    end else begin
      idx = int'(ALU_ResultM[IW+1:2]);
      k = -1;
      foreach (rtag[j]) if (rtag[j] == idx) k = j;
      e_rw = RegWriteM; e_rs = ResultSrcM; e_rd = RD_M;
      e_pc = PCPlus4M; e_alu = ALU_ResultM;
      e_rchk = 0;
      if (MemWriteM) begin
        if (k >= 0) rsp[k] = WriteDataM;
        else begin
          mdata[idx] = WriteDataM;
          mwr[idx]   = 1'b1;
          mbad[idx]  = inject_parity_err;
        end
      end else if (ResultSrcM) begin
        e_rchk = 1;
        if (k >= 0) e_rdata = rsp[k];
        else if (!mwr[idx]) e_rdata = 32'h0;
        else begin
          e_rdata = mdata[idx];
          if (mbad[idx]) begin
            if (!e_flag) e_faddr = ALU_ResultM;
            e_flag = 1'b1;
            if (rtag.size() < NSP) begin
              rtag.push_back(idx);
              rsp.push_back(mdata[idx]);
            end else begin
              e_exh = 1'b1;
            end
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model one step after every edge.
  always @(posedge clk) begin
    #1;
    chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
    chk("RD_W", 32'(RD_W), 32'(e_rd));
    chk("PCPlus4W", PCPlus4W, e_pc);
    chk("ALU_ResultW", ALU_ResultW, e_alu);
    chk("mem_fault_flag", 32'(mem_fault_flag), 32'(e_flag));
    chk("spares_exhausted", 32'(spares_exhausted), 32'(e_exh));
    chk("fault_addr", fault_addr, e_faddr);
    if (e_rchk) chk("ReadDataW", ReadDataW, e_rdata);
  end

  task automatic op(input bit w, input bit l, input logic [31:0] a, input logic [31:0] d,
                    input bit inj, input logic [4:0] rd, input logic [31:0] pc);
    @(negedge clk);
    MemWriteM = w; ResultSrcM = l; ALU_ResultM = a; WriteDataM = d;
    inject_parity_err = inj; RD_M = rd; PCPlus4M = pc;
    RegWriteM = 1'($urandom_range(0, 1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'h0);
    chk({tag, " RD_W"}, 32'(RD_W), 32'h0);
    chk({tag, " PCPlus4W"}, PCPlus4W, 32'h0);
    chk({tag, " ALU_ResultW"}, ALU_ResultW, 32'h0);
    chk({tag, " ReadDataW"}, ReadDataW, 32'h0);
    chk({tag, " mem_fault_flag"}, 32'(mem_fault_flag), 32'h0);
    chk({tag, " spares_exhausted"}, 32'(spares_exhausted), 32'h0);
    chk({tag, " fault_addr"}, fault_addr, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bit          inj;
    // Asynchronous reset between edges.
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    #5 rst = 1'b1;

    op(0, 1, 32'h40, 32'h0, 0, 5'd1, 32'h4);
    settle();
    chk("load0x40 ReadDataW", ReadDataW, 32'h0);
    chk("load0x40 fault", 32'(mem_fault_flag), 32'h0);

    // Store/load round trip.
    op(1, 0, 32'h10, 32'hDEADBEEF, 0, 5'd3, 32'h100);
    op(0, 1, 32'h10, 32'h0, 0, 5'd5, 32'h104);
    settle();
    chk("roundtrip ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("roundtrip RD_W", 32'(RD_W), 32'd5);
    chk("roundtrip PCPlus4W", PCPlus4W, 32'h104);
    chk("roundtrip fault", 32'(mem_fault_flag), 32'h0);

    // Address wrap modulo DEPTH words.
    op(1, 0, 32'h1010, 32'h12345678, 0, 5'd0, 32'h0);
    op(0, 1, 32'h0010, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("wrap ReadDataW", ReadDataW, 32'h12345678);

`ifdef MEMORY_FAULT_INJECT_EN
    op(1, 0, 32'h20, 32'hA5A5A5A5, 1, 5'd0, 32'h0);
    op(0, 1, 32'h20, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("inject ReadDataW", ReadDataW, 32'hA5A5A5A5);
    chk("inject fault", 32'(mem_fault_flag), 32'h1);
    chk("inject fault_addr", fault_addr, 32'h20);
    op(1, 0, 32'h20, 32'h11111111, 1, 5'd0, 32'h0);
    op(0, 1, 32'h20, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("remap ReadDataW", ReadDataW, 32'h11111111);
    chk("remap exhausted", 32'(spares_exhausted), 32'h0);
    op(1, 0, 32'h24, 32'h0000_0F0F, 1, 5'd0, 32'h0);
    op(0, 1, 32'h24, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("second spare exhausted", 32'(spares_exhausted), 32'h0);
    op(1, 0, 32'h28, 32'h0BAD_F00D, 1, 5'd0, 32'h0);
    op(0, 1, 32'h28, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("third exhausted", 32'(spares_exhausted), 32'h1);
    chk("third fault_addr", fault_addr, 32'h20);
    op(0, 1, 32'h28, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("reload 0x28 ReadDataW", ReadDataW, 32'h0BAD_F00D);
`endif

    // Reset in the middle of a store drops the store.
    op(1, 0, 32'h30, 32'hCAFEF00D, 0, 5'd7, 32'h200);
    #2 rst = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk);
    #3 rst = 1'b1;
    op(0, 1, 32'h30, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("after reset load 0x30", ReadDataW, 32'h0);
    op(0, 1, 32'h20, 32'h0, 0, 5'd0, 32'h0);
    settle();
    chk("after reset load 0x20", ReadDataW, 32'h0);
    chk("after reset fault", 32'(mem_fault_flag), 32'h0);

    // Randomized traffic over a small index pool so addresses collide.
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      r = int'($urandom_range(0, 2));
      inj = 1'b0;
`ifdef MEMORY_FAULT_INJECT_EN
      inj = ($urandom_range(0, 5) == 0);
`endif
      op(r == 0, (r == 1) || ($urandom_range(0, 3) == 0), a, $urandom, inj,
         5'($urandom), $urandom);
    end
    op(0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    settle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
